// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and constants for the fetch stage slice.
//   - N, INST_BUFF_DEPTH : default fetch width and instruction buffer depth
//   - DEFAULT_RESET_PC   : default first fetch PC (line aligned)
//   - INST_PACKET        : one decoded-slot packet handed to inst_buffer
//   - fetch_state_e      : fetch FSM states
//   - line_mask()        : mask that clears the byte offset inside a line
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int          N                = 2;
  localparam int          INST_BUFF_DEPTH  = 8;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } INST_PACKET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // A line holds fetch_width 4-byte instructions, so the line start is the
  // address with its low log2(4*fetch_width) bits cleared.
  function automatic logic [31:0] line_mask(input int fetch_width);
    return ~(32'(4 * fetch_width) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_align.sv
// ---------------------------------------------------------------------------
// fetch_align
//   Combinational packer: takes the buffered line and the current fetch PC
//   and produces the leading num_accept packets, starting at the slot the PC
//   points into. Packets at or beyond num_accept are all-zero.
//   Ports:
//     line_buf   in  32*FETCH_WIDTH : buffered line, slot i = [32i+31:32i]
//     pc         in  32             : PC of the first packet to hand out
//     num_accept in  $clog2(DEPTH+1): number of packets to emit
//     out_insts  out INST_PACKET[FETCH_WIDTH]
// ---------------------------------------------------------------------------
module fetch_align
  import fetch_unit_pkg::*;
#(
  parameter int FETCH_WIDTH = N,
  parameter int DEPTH       = INST_BUFF_DEPTH
) (
  input  logic [32*FETCH_WIDTH-1:0]         line_buf,
  input  logic [31:0]                       pc,
  input  logic [$clog2(DEPTH+1)-1:0]        num_accept,
  output INST_PACKET [FETCH_WIDTH-1:0]      out_insts
);

  localparam int          CNT_W     = $clog2(DEPTH + 1);
  localparam logic [31:0] SLOT_MASK = 32'(FETCH_WIDTH - 1);

  logic [31:0] slot_off;

  assign slot_off = (pc >> 2) & SLOT_MASK;

  // The slot index wraps with the mask so that unused packets never index
  // past the line; those packets are zeroed anyway.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      out_insts[k] = '0;
      if (CNT_W'(k) < num_accept) begin
        out_insts[k].valid = 1'b1;
        out_insts[k].inst  = line_buf[32*((slot_off + 32'(k)) & SLOT_MASK) +: 32];
        out_insts[k].PC    = pc + 32'(4 * k);
        out_insts[k].NPC   = pc + 32'(4 * k + 4);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Front-end fetch stage. Holds the fetch PC, issues one line-aligned
//   request at a time, buffers the returned line and hands as many packets
//   to inst_buffer as it has room for. Redirects are accepted in any cycle;
//   a redirect while a request is outstanding marks its response as stale.
//   Ports:
//     clock          in  1              : clock
//     reset          in  1              : asynchronous, active-low reset
//     redirect_valid in  1              : recovery redirect
//     redirect_pc    in  32             : new PC, bits [1:0] ignored
//     open_entries   in  $clog2(DEPTH+1): free inst_buffer slots
//     mem_req_valid  out 1              : fetch request
//     mem_req_ready  in  1              : memory accepts the request
//     mem_req_addr   out 32             : line-aligned request address
//     mem_rsp_valid  in  1              : line returned (single-cycle pulse)
//     mem_rsp_data   in  32*FETCH_WIDTH : returned line
//     out_insts      out INST_PACKET[FETCH_WIDTH]
//     num_accept     out $clog2(DEPTH+1): valid leading packets
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          FETCH_WIDTH = N,
  parameter int          DEPTH       = INST_BUFF_DEPTH,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic [$clog2(DEPTH+1)-1:0]   open_entries,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [31:0]                  mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [32*FETCH_WIDTH-1:0]    mem_rsp_data,
  output INST_PACKET [FETCH_WIDTH-1:0] out_insts,
  output logic [$clog2(DEPTH+1)-1:0]   num_accept
);

  localparam int          CNT_W     = $clog2(DEPTH + 1);
  localparam logic [31:0] LINE_MASK = line_mask(FETCH_WIDTH);
  localparam logic [31:0] SLOT_MASK = 32'(FETCH_WIDTH - 1);

  fetch_state_e              state_q, state_d;
  logic [31:0]               pc_q, pc_d;
  logic [32*FETCH_WIDTH-1:0] line_q, line_d;
  logic                      squash_q, squash_d;
  logic [CNT_W-1:0]          slot_off;
  logic [CNT_W-1:0]          slot_rem;
  logic [CNT_W-1:0]          drain_cnt;

  // Position of the PC inside the buffered line and how many slots are
  // still left to hand out from it.
  assign slot_off  = CNT_W'((pc_q >> 2) & SLOT_MASK);
  assign slot_rem  = CNT_W'(FETCH_WIDTH) - slot_off;
  assign drain_cnt = (slot_rem < open_entries) ? slot_rem : open_entries;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      line_q   <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      line_q   <= line_d;
      squash_q <= squash_d;
    end
  end

  // Next-state and output logic. The redirect override comes last so it
  // wins over whatever the normal state behaviour decided this cycle.
  // A redirect in WAIT with no response keeps the request outstanding and
  // flags its eventual response as stale instead of abandoning it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    line_d        = line_q;
    squash_d      = squash_q;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    num_accept    = '0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        mem_req_valid = !redirect_valid;
        mem_req_addr  = pc_q & LINE_MASK;
        if (!redirect_valid && mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            line_d  = mem_rsp_data;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        num_accept = drain_cnt;
        pc_d       = pc_q + (32'(drain_cnt) << 2);
        if (drain_cnt == slot_rem) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'h3;
      num_accept = '0;
      line_d     = line_q;
      if (state_q == WAIT && !mem_rsp_valid) begin
        state_d  = WAIT;
        squash_d = 1'b1;
      end else begin
        state_d  = FETCH;
        squash_d = 1'b0;
      end
    end
  end

  fetch_align #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .DEPTH       (DEPTH)
  ) u_align (
    .line_buf   (line_q),
    .pc         (pc_q),
    .num_accept (num_accept),
    .out_insts  (out_insts)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with FETCH_WIDTH=2, DEPTH=8, RESET_PC=0.
//   Inputs change 1 time unit after the rising edge; outputs are checked on
//   the falling edge. The scenarios run back to back, each picking up the
//   unit in the state the previous one left it.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic                  clock;
  logic                  reset;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [3:0]            open_entries;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_req_addr;
  logic                  mem_rsp_valid;
  logic [63:0]           mem_rsp_data;
  INST_PACKET [1:0]      out_insts;
  logic [3:0]            num_accept;

  int total_checks;
  int bad_checks;

  fetch_unit #(
    .FETCH_WIDTH (2),
    .DEPTH       (8),
    .RESET_PC    (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .open_entries   (open_entries),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_insts      (out_insts),
    .num_accept     (num_accept)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction word stored at a byte address: a tag plus the address.
  function automatic logic [31:0] inst_at(input logic [31:0] addr);
    return 32'hC0DE_0000 + addr;
  endfunction

  function automatic logic [63:0] line_at(input logic [31:0] base);
    return {inst_at(base + 32'd4), inst_at(base)};
  endfunction

  function automatic INST_PACKET pkt(input logic [31:0] pc);
    INST_PACKET p;
    p.valid = 1'b1;
    p.inst  = inst_at(pc);
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Reset holds everything at zero, then the first request follows one
  // cycle after release.
  task automatic test_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    open_entries   = 4'd8;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      bad_checks++;
      $display("[TB] FAIL reset_req got valid=%b addr=%h want valid=0 addr=0", mem_req_valid, mem_req_addr);
    end
    total_checks++;
    if (num_accept !== 4'd0 || out_insts !== '0) begin
      bad_checks++;
      $display("[TB] FAIL reset_out got num=%0d out=%h want 0", num_accept, out_insts);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL idle_req got %b want 0", mem_req_valid);
    end
    next_cycle();
  endtask

  // Line 0x0 fetched and fully drained, then line 0x8 requested.
  task automatic test_basic_fetch();
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      bad_checks++;
      $display("[TB] FAIL first_req got valid=%b addr=%h want 1/00000000", mem_req_valid, mem_req_addr);
    end
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h0);
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd0 || mem_req_valid !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL wait_quiet got num=%0d req=%b want 0/0", num_accept, mem_req_valid);
    end
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd2) begin
      bad_checks++;
      $display("[TB] FAIL basic_num got %0d want 2", num_accept);
    end
    total_checks++;
    if (out_insts[0] !== pkt(32'h0) || out_insts[1] !== pkt(32'h4)) begin
      bad_checks++;
      $display("[TB] FAIL basic_pkts got %h want %h", out_insts, {pkt(32'h4), pkt(32'h0)});
    end
    next_cycle();
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8) begin
      bad_checks++;
      $display("[TB] FAIL next_req got valid=%b addr=%h want 1/00000008", mem_req_valid, mem_req_addr);
    end
    next_cycle();
  endtask

  // Line 0x8 drained, then a redirect to 0x14 in FETCH.
  task automatic test_redirect_fetch();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h8);
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd2 || out_insts[1] !== pkt(32'hC)) begin
      bad_checks++;
      $display("[TB] FAIL line8 got num=%0d pkt1=%h want 2/%h", num_accept, out_insts[1], pkt(32'hC));
    end
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h16;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b0 || num_accept !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL redir_cycle got req=%b num=%0d want 0/0", mem_req_valid, num_accept);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10) begin
      bad_checks++;
      $display("[TB] FAIL redir_req got valid=%b addr=%h want 1/00000010", mem_req_valid, mem_req_addr);
    end
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h10);
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd1 || out_insts[0] !== pkt(32'h14) || out_insts[1] !== '0) begin
      bad_checks++;
      $display("[TB] FAIL redir_pkt got num=%0d out=%h want 1/%h", num_accept, out_insts, {97'd0, pkt(32'h14)});
    end
    next_cycle();
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h18) begin
      bad_checks++;
      $display("[TB] FAIL after_redir_req got valid=%b addr=%h want 1/00000018", mem_req_valid, mem_req_addr);
    end
    next_cycle();
  endtask

  // Line 0x18 drained normally, line 0x20 drained under backpressure.
  task automatic test_backpressure();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h18);
    next_cycle();
    mem_rsp_valid = 1'b0;
    next_cycle();
    @(negedge clock);
    total_checks++;
    if (mem_req_addr !== 32'h20) begin
      bad_checks++;
      $display("[TB] FAIL req20 got %h want 00000020", mem_req_addr);
    end
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h20);
    open_entries  = 4'd0;
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd0 || out_insts !== '0) begin
      bad_checks++;
      $display("[TB] FAIL bp_zero got num=%0d out=%h want 0", num_accept, out_insts);
    end
    next_cycle();
    open_entries = 4'd1;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd1 || out_insts[0] !== pkt(32'h20) || out_insts[1] !== '0) begin
      bad_checks++;
      $display("[TB] FAIL bp_first got num=%0d out=%h want 1/%h", num_accept, out_insts, pkt(32'h20));
    end
    next_cycle();
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd1 || out_insts[0] !== pkt(32'h24)) begin
      bad_checks++;
      $display("[TB] FAIL bp_second got num=%0d pkt0=%h want 1/%h", num_accept, out_insts[0], pkt(32'h24));
    end
    next_cycle();
    open_entries = 4'd8;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h28) begin
      bad_checks++;
      $display("[TB] FAIL bp_next_req got valid=%b addr=%h want 1/00000028", mem_req_valid, mem_req_addr);
    end
    next_cycle();
  endtask

  // Redirect while waiting on line 0x30; its late response must be dropped.
  task automatic test_squash();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h28);
    next_cycle();
    mem_rsp_valid = 1'b0;
    next_cycle();
    @(negedge clock);
    total_checks++;
    if (mem_req_addr !== 32'h30) begin
      bad_checks++;
      $display("[TB] FAIL req30 got %h want 00000030", mem_req_addr);
    end
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b0 || num_accept !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL squash_hold got req=%b num=%0d want 0/0", mem_req_valid, num_accept);
    end
    next_cycle();
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h30);
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
      bad_checks++;
      $display("[TB] FAIL squash_drop got num=%0d req=%b addr=%h want 0/1/00000040", num_accept, mem_req_valid, mem_req_addr);
    end
    next_cycle();
  endtask

  // Redirect coinciding with the response for line 0x40.
  task automatic test_redirect_rsp();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = line_at(32'h40);
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL rsp_redir_cycle got num=%0d want 0", num_accept);
    end
    next_cycle();
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80) begin
      bad_checks++;
      $display("[TB] FAIL rsp_redir_req got num=%0d req=%b addr=%h want 0/1/00000080", num_accept, mem_req_valid, mem_req_addr);
    end
    next_cycle();
  endtask

  // Asynchronous reset in the middle of a DRAIN cycle, then a stalled
  // request that must hold its address.
  task automatic test_reset_mid_drain();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line_at(32'h80);
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    total_checks++;
    if (num_accept !== 4'd2 || out_insts[0] !== pkt(32'h80)) begin
      bad_checks++;
      $display("[TB] FAIL drain80 got num=%0d pkt0=%h want 2/%h", num_accept, out_insts[0], pkt(32'h80));
    end
    #1;
    reset = 1'b0;
    #1;
    total_checks++;
    if (num_accept !== 4'd0 || out_insts !== '0 || mem_req_valid !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL async_reset got num=%0d out=%h req=%b want 0", num_accept, out_insts, mem_req_valid);
    end
    next_cycle();
    reset         = 1'b1;
    mem_req_ready = 1'b0;
    @(negedge clock);
    total_checks++;
    if (mem_req_valid !== 1'b0 || num_accept !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL post_reset_idle got req=%b num=%0d want 0/0", mem_req_valid, num_accept);
    end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
        bad_checks++;
        $display("[TB] FAIL stall_req%0d got valid=%b addr=%h want 1/00000000", i, mem_req_valid, mem_req_addr);
      end
      next_cycle();
    end
    mem_req_ready = 1'b1;
    next_cycle();
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    test_reset();
    test_basic_fetch();
    test_redirect_fetch();
    test_backpressure();
    test_squash();
    test_redirect_rsp();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage feeding `inst_buffer`. Holds the architectural fetch PC and issues line-aligned requests to instruction memory, with one request in flight at a time. Packs returned instructions into `INST_PACKET`s and hands `inst_buffer` as many as its `open_entries` allows. Accepts branch-recovery redirects at any time and discards stale responses.

## Interface
Parameters:
- `FETCH_WIDTH`, default `` `N ``: instructions per line. Power of 2, ≤ `INST_BUFF_DEPTH`. Line size is 4·FETCH_WIDTH bytes.
- `DEPTH`, default `` `INST_BUFF_DEPTH ``: sizes `open_entries` and `num_accept`.
- `RESET_PC`, default 32'h0: first fetch PC. Must be line-aligned.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `redirect_valid` in 1: recovery redirect.
- `redirect_pc` in 32: new fetch PC. Bits [1:0] are ignored and treated as 0.
- `open_entries` in $clog2(DEPTH+1): free slots in `inst_buffer` this cycle.
- `mem_req_valid` out 1: fetch request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 32: line-aligned address.
- `mem_rsp_valid` in 1: line returned, single-cycle pulse.
- `mem_rsp_data` in 32·FETCH_WIDTH: slot i is bits [32i+31:32i].
- `out_insts` out `INST_PACKET`[FETCH_WIDTH]: packed packets to `inst_buffer`. The top level zero-pads this to DEPTH.
- `num_accept` out $clog2(DEPTH+1): count of valid leading packets in `out_insts`.

## Operation
- Registered state:
  - `state` ∈ {IDLE, FETCH, WAIT, DRAIN}
  - `pc`
  - `line_buf`
  - `squash` flag
- IDLE: all outputs are 0. Always moves to FETCH on the next edge.
- FETCH:
  - `mem_req_valid = !redirect_valid`.
  - `mem_req_addr = pc` with its low log2(4·FETCH_WIDTH) bits cleared.
  - On a request handshake, go to WAIT.
- WAIT, on `mem_rsp_valid`:
  - If `squash`=1: drop the data, clear `squash`, go to FETCH.
  - Otherwise: latch the data into `line_buf`, go to DRAIN.
- DRAIN:
  - Start slot is `off = pc[log2(4·FW)-1:2]`. Remaining count is `rem = FW − off`.
  - `num_accept = min(rem, open_entries)`.
  - For k < `num_accept`, `out_insts[k]` = {valid=1, inst=line_buf[off+k], PC=pc+4k, NPC=pc+4k+4}.
  - Advance `pc` by 4·`num_accept`.
  - If `num_accept == rem`, go to FETCH (pc is now the next line start). Otherwise stay in DRAIN.
- Packet rule: slots ≥ `num_accept` are all-zero. `num_accept` is 0 outside DRAIN.
- Redirect has priority over everything in the same cycle:
  - `pc <= redirect_pc` and `num_accept = 0`.
  - IDLE, FETCH, DRAIN: go to FETCH. Any line in `line_buf` is discarded. No request is issued in the redirect cycle.
  - WAIT without `mem_rsp_valid`: stay in WAIT and set `squash`. This keeps one request outstanding.
  - WAIT with `mem_rsp_valid`: drop the response, go to FETCH, `squash` stays 0.
  - Repeated redirects while `squash`=1: only `pc` is updated.
- Arithmetic: `pc` wraps modulo 2^32. `min` is computed at $clog2(DEPTH+1) width.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, pc=RESET_PC, squash=0, line_buf=0.
  - `mem_req_valid`=0, `mem_req_addr`=0, `num_accept`=0, `out_insts`=0.
  - These values hold for as long as `reset` is low, including when it is asserted mid-operation.
- The first request appears 1 cycle after reset deassertion.
- A response at edge t produces output in cycle t+1, since DRAIN reads `line_buf`.
- The next request is issued the cycle after the last slot of a line is accepted.
- A fully-accepted line from a 1-cycle memory costs 3 cycles: FETCH, WAIT, DRAIN.
- `mem_req_valid` stays high with a stable address until `mem_req_ready`. The exception is a redirect, which drops it for that cycle only.
- All outputs depend combinationally on the registers, plus `open_entries` and `redirect_valid`. No output depends on `mem_rsp_*` within the same cycle.

## Structure
- `sys_defs.svh` holds:
  - `INST_PACKET` (valid, inst, PC, NPC)
  - `` `N ``, `` `INST_BUFF_DEPTH ``
  - the new `` `RESET_PC `` define
- One combinational sub-module, `fetch_align`. Inputs are `line_buf`, `pc`, and `num_accept`. Output is the packed `out_insts`.
- The FSM, `pc`, and `squash` live in `fetch_unit`.

## Test plan
All scenarios use FETCH_WIDTH=2, RESET_PC=0, and a 1-cycle memory unless stated.
1. Reset release, `mem_req_ready`=1, `open_entries`=8 → request addr 0x0. Then `num_accept`=2 with PCs 0x0/0x4 and NPCs 0x4/0x8. Then request addr 0x8.
2. Redirect to 0x14 while in FETCH → no request that cycle. Next request is addr 0x10. Delivery has `num_accept`=1, PC 0x14. Next request is 0x18.
3. Line 0x20 delivered under backpressure: `open_entries`=1 for two cycles → PC 0x20, then PC 0x24, each with `num_accept`=1. Next request is 0x28. With `open_entries`=0 the unit stays in DRAIN with `num_accept`=0.
4. Redirect to 0x40 in WAIT for line 0x30, response arriving 3 cycles later → that response is dropped and `num_accept` stays 0. Next request is 0x40.
5. Redirect to 0x80 in the same cycle as `mem_rsp_valid` → no delivery. Request addr 0x80 appears the next cycle.
6. `reset` pulled low mid-DRAIN with `num_accept`=2 → `num_accept`, `out_insts`, and `mem_req_valid` go to 0 immediately. After release, the first request is addr 0x0.
